// File: rtl/cva6_cfg_reader.sv
// Read-only view of the CVA6 configuration table: single-entry reads or a streamed dump of every entry.
// Optional feature: CVA6_CFG_READER_CHECKSUM_EN adds entry 25, the XOR of entries 0..24.
module cva6_cfg_reader #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IdxWidth-1:0]  req_idx_i,
  input  logic                 dump_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic [IdxWidth-1:0]  rsp_idx_o,
  output logic                 rsp_err_o,
  output logic                 rsp_last_o,
  output logic [1:0]           dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a raised rsp_valid_o keeps its payload stable until that transfer completes.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DUMP = 2'd2
  } state_e;

  localparam int unsigned NumBase = 25;
`ifdef CVA6_CFG_READER_CHECKSUM_EN
  localparam int unsigned NumEntries = 26;
`else
  localparam int unsigned NumEntries = 25;
`endif
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumEntries - 1);

  // Values mirror cva6_config_pkg for the default CVA6 configuration.
  function automatic logic [31:0] base_val(input int unsigned i);
    case (i)
      0:  base_val = 32'd64;
      1:  base_val = 32'd1;
      7:  base_val = 32'd1;
      8:  base_val = 32'd1;
      9:  base_val = 32'd1;
      10: base_val = 32'd16384;
      11: base_val = 32'd4;
      12: base_val = 32'd128;
      13: base_val = 32'd32768;
      14: base_val = 32'd8;
      15: base_val = 32'd128;
      16: base_val = 32'd2;
      17: base_val = 32'd8;
      18: base_val = 32'd16;
      19: base_val = 32'd16;
      20: base_val = 32'd2;
      21: base_val = 32'd32;
      22: base_val = 32'd128;
      23: base_val = 32'd8;
      24: base_val = 32'd1;
      default: base_val = 32'd0;
    endcase
  endfunction

`ifdef CVA6_CFG_READER_CHECKSUM_EN
  function automatic logic [31:0] calc_checksum();
    logic [31:0] acc;
    acc = 32'd0;
    for (int unsigned i = 0; i < NumBase; i++) acc = acc ^ base_val(i);
    return acc;
  endfunction

  localparam logic [31:0] Checksum = calc_checksum();
`endif

  function automatic logic [31:0] entry_val(input int unsigned i);
    entry_val = base_val(i);
`ifdef CVA6_CFG_READER_CHECKSUM_EN
    if (i == NumBase) entry_val = Checksum;
`endif
  endfunction

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic                hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // idx_q doubles as the captured request index and the dump counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = RESP;
          idx_d   = req_idx_i;
        end else if (dump_i) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      DUMP: begin
        if (rsp_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hit         = 32'(idx_q) < NumEntries;
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q != IDLE);
  assign rsp_data_o  = (rsp_valid_o && hit) ? DataWidth'(entry_val(32'(idx_q))) : '0;
  assign rsp_idx_o   = rsp_valid_o ? idx_q : '0;
  assign rsp_err_o   = (state_q == RESP) && !hit;
  assign rsp_last_o  = (state_q == RESP) || ((state_q == DUMP) && (idx_q == LastIdx));
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cva6_cfg_reader.sv
// Directed bench for cva6_cfg_reader: reset, single reads, backpressure, errors, collisions, dump, reset abort.
module tb_cva6_cfg_reader;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  req_idx_i;
  logic        dump_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_idx_o;
  logic        rsp_err_o;
  logic        rsp_last_o;
  logic [1:0]  dbg_state_o;

  int vectors = 0;
  int miscompares = 0;

`ifdef CVA6_CFG_READER_CHECKSUM_EN
  localparam int DumpLen = 26;
`else
  localparam int DumpLen = 25;
`endif

  int unsigned exp_tab [26] = '{64, 1, 0, 0, 0, 0, 0, 1, 1, 1, 16384, 4, 128, 32768, 8, 128,
                                2, 8, 16, 16, 2, 32, 128, 8, 1, 32'hC0ED};

  cva6_cfg_reader dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_idx_i   (req_idx_i),
    .dump_i      (dump_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_idx_o   (rsp_idx_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_last_o  (rsp_last_o),
    .dbg_state_o (dbg_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d,
                         input logic [4:0] idx, input logic e, input logic l);
    chk({tag, ".valid"}, 32'(rsp_valid_o), 32'(v));
    chk({tag, ".data"},  rsp_data_o, d);
    chk({tag, ".idx"},   32'(rsp_idx_o), 32'(idx));
    chk({tag, ".err"},   32'(rsp_err_o), 32'(e));
    chk({tag, ".last"},  32'(rsp_last_o), 32'(l));
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_idx_i = '0;
    dump_i = 1'b0;
    rsp_ready_i = 1'b0;
    tick();
    tick();
    chk_rsp("reset", 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    chk("reset.req_ready", 32'(req_ready_o), 32'd1);
    rst_i = 1'b0;
    tick();

    // single read of index 0
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_idx_i = 5'd0;
    tick();
    req_valid_i = 1'b0;
    chk_rsp("read0", 1'b1, 32'd64, 5'd0, 1'b0, 1'b1);
    chk("read0.req_ready", 32'(req_ready_o), 32'd0);
    tick();
    chk("read0.done_valid", 32'(rsp_valid_o), 32'd0);
    chk("read0.done_ready", 32'(req_ready_o), 32'd1);

    // backpressure on index 13
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_idx_i = 5'd13;
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_rsp("bp13", 1'b1, 32'd32768, 5'd13, 1'b0, 1'b1);
      chk("bp13.req_ready", 32'(req_ready_o), 32'd0);
      tick();
    end
    chk_rsp("bp13.held", 1'b1, 32'd32768, 5'd13, 1'b0, 1'b1);
    rsp_ready_i = 1'b1;
    tick();
    chk("bp13.done_valid", 32'(rsp_valid_o), 32'd0);
    chk("bp13.done_ready", 32'(req_ready_o), 32'd1);

    // unmapped index 31
    req_valid_i = 1'b1;
    req_idx_i = 5'd31;
    tick();
    req_valid_i = 1'b0;
    chk_rsp("err31", 1'b1, 32'd0, 5'd31, 1'b1, 1'b1);
    tick();

    // index 25: checksum entry only when the feature is built in
    req_valid_i = 1'b1;
    req_idx_i = 5'd25;
    tick();
    req_valid_i = 1'b0;
`ifdef CVA6_CFG_READER_CHECKSUM_EN
    chk_rsp("idx25", 1'b1, 32'hC0ED, 5'd25, 1'b0, 1'b1);
`else
    chk_rsp("idx25", 1'b1, 32'd0, 5'd25, 1'b1, 1'b1);
`endif
    tick();
    chk("idx25.done_valid", 32'(rsp_valid_o), 32'd0);

    // request and dump together: request wins; dump during RESP ignored
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    dump_i = 1'b1;
    req_idx_i = 5'd20;
    tick();
    req_valid_i = 1'b0;
    dump_i = 1'b0;
    chk_rsp("coll", 1'b1, 32'd2, 5'd20, 1'b0, 1'b1);
    dump_i = 1'b1;
    tick();
    dump_i = 1'b0;
    chk_rsp("coll.dump_in_resp", 1'b1, 32'd2, 5'd20, 1'b0, 1'b1);
    rsp_ready_i = 1'b1;
    tick();
    chk("coll.done_valid", 32'(rsp_valid_o), 32'd0);
    tick();
    chk("coll.no_dump", 32'(rsp_valid_o), 32'd0);
    chk("coll.req_ready", 32'(req_ready_o), 32'd1);

    // full dump, with a stray request and one backpressure stall inside it
    dump_i = 1'b1;
    tick();
    dump_i = 1'b0;
    for (int i = 0; i < DumpLen; i++) begin
      if (i == 10) begin
        rsp_ready_i = 1'b0;
        tick();
        tick();
        chk("dump.stall_data", rsp_data_o, exp_tab[i]);
        chk("dump.stall_idx", 32'(rsp_idx_o), 32'(i));
        rsp_ready_i = 1'b1;
      end
      if (i == 5) begin
        req_valid_i = 1'b1;
        req_idx_i = 5'd3;
      end else begin
        req_valid_i = 1'b0;
      end
      chk_rsp("dump", 1'b1, exp_tab[i], 5'(i), 1'b0, (i == DumpLen - 1));
      chk("dump.req_ready", 32'(req_ready_o), 32'd0);
      tick();
    end
    req_valid_i = 1'b0;
    chk("dump.end_valid", 32'(rsp_valid_o), 32'd0);
    chk("dump.end_ready", 32'(req_ready_o), 32'd1);
    tick();
    chk("dump.no_stray_resp", 32'(rsp_valid_o), 32'd0);

    // reset in the middle of a dump
    dump_i = 1'b1;
    tick();
    dump_i = 1'b0;
    tick();
    tick();
    tick();
    chk_rsp("rstdump.pre", 1'b1, exp_tab[3], 5'd3, 1'b0, 1'b0);
    rst_i = 1'b1;
    #1;
    chk_rsp("rstdump.async", 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    chk("rstdump.async_ready", 32'(req_ready_o), 32'd1);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstdump.after_valid", 32'(rsp_valid_o), 32'd0);
      chk("rstdump.after_ready", 32'(req_ready_o), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cva6_cfg_reader.md
CVA6_CFG_READER -- requirements
Module: cva6_cfg_reader

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning width of every returned configuration word.
REQ-002 SHALL have parameter IdxWidth, default 5, meaning width of the entry index.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports req_valid_i (input, 1) and req_ready_o (output, 1): single-entry read request handshake.
REQ-006 SHALL have port req_idx_i, input, IdxWidth, the entry index requested.
REQ-007 SHALL have port dump_i, input, 1, a one-cycle pulse that starts streaming all entries.
REQ-008 SHALL have ports rsp_valid_o (output, 1) and rsp_ready_i (input, 1): response handshake.
REQ-009 SHALL have ports rsp_data_o (output, DataWidth), rsp_idx_o (output, IdxWidth), rsp_err_o (output, 1) and rsp_last_o (output, 1), the response payload.

Function
REQ-010 SHALL hold a constant table taken from cva6_config_pkg, one entry per index:
- 0 Xlen, 1 FpuEn, 2 F16En, 3 F16AltEn, 4 F8En, 5 F8AltEn, 6 FVecEn
- 7 CvxifEn, 8 CExtEn, 9 AExtEn
- 10 IcacheByteSize, 11 IcacheSetAssoc, 12 IcacheLineWidth
- 13 DcacheByteSize, 14 DcacheSetAssoc, 15 DcacheLineWidth
- 16 NrCommitPorts, 17 NrScoreboardEntries, 18 InstrTlbEntries, 19 DataTlbEntries
- 20 RASDepth, 21 BTBEntries, 22 BHTEntries, 23 NrPMPEntries, 24 PerfCounterEn
- Each value is zero-extended to DataWidth.
REQ-011 SHALL implement an FSM with states IDLE, RESP and DUMP.
REQ-012 SHALL drive req_ready_o high only in IDLE.
REQ-013 IDLE with req_valid_i high: SHALL accept the request and go to RESP, with rsp_valid_o high exactly one cycle after acceptance.
REQ-014 In RESP, SHALL hold rsp_data_o, rsp_idx_o, rsp_err_o and rsp_valid_o stable until rsp_ready_i is high, then return to IDLE on that edge.
REQ-015 For an index with no table entry: SHALL respond with rsp_err_o=1 and rsp_data_o=0.
- For a valid index, rsp_err_o SHALL be 0.
REQ-016 SHALL drive rsp_last_o=1 for every single-entry response.
REQ-017 IDLE with dump_i high and req_valid_i low: SHALL enter DUMP with an internal counter at 0.
REQ-018 IDLE with dump_i and req_valid_i both high: the request SHALL win and dump_i SHALL be dropped.
REQ-019 In DUMP, SHALL present entry[counter] with rsp_valid_o=1 and advance the counter on each rsp_valid_o&&rsp_ready_i.
- Under backpressure the payload SHALL stay stable.
- The dump SHALL never emit an error response.
REQ-020 rsp_last_o SHALL be 1 on the final dump word; that word's handshake SHALL return the FSM to IDLE.
REQ-021 dump_i outside IDLE and req_valid_i outside IDLE SHALL be ignored (not queued).
REQ-022 Throughput SHALL be one dump word per cycle while rsp_ready_i is held high.

Reset
REQ-023 While rst_i is high: state=IDLE, counter=0, rsp_valid_o=0, rsp_data_o=0, rsp_idx_o=0, rsp_err_o=0, rsp_last_o=0.
- Because IDLE is the reset state, req_ready_o SHALL be 1.
REQ-024 Reset asserted mid-RESP or mid-DUMP SHALL abort immediately, with no further response beats after deassertion.

Configuration
REQ-025 Macro CVA6_CFG_READER_CHECKSUM_EN defined: index 25 SHALL be valid and return the XOR of entries 0..24.
- The dump SHALL be 26 words, with rsp_last_o on index 25.
REQ-026 Macro CVA6_CFG_READER_CHECKSUM_EN undefined: index 25 SHALL return an error response.
- The dump SHALL be 25 words, with rsp_last_o on index 24.

Verification
REQ-027 Single read: req idx=0 accepted, rsp_ready_i=1 -> next cycle rsp_valid_o=1, data=64, err=0, last=1; req_ready_o back to 1 the following cycle.
REQ-028 Backpressure: req idx=13, rsp_ready_i low for 5 cycles -> data=32768 held stable; req_ready_o=0 throughout; completes on the first ready cycle.
REQ-029 Error: req idx=31 -> err=1, data=0; with the macro undefined, idx=25 -> err=1.
REQ-030 Dump with rsp_ready_i=1: pulse dump_i -> consecutive words 64,1,0,0,0,0,0,1,1,1,16384,4,128,32768,8,128,2,8,16,16,2,32,128,8,1.
- With the macro defined, a final word 0xC0ED with last=1 follows.
REQ-031 Collision: dump_i and req_valid_i (idx=20) in the same IDLE cycle -> a single response data=2, no dump follows; dump_i pulsed during RESP -> ignored.
REQ-032 Reset mid-dump after 3 words -> rsp_valid_o=0 immediately; after release, IDLE with req_ready_o=1 and no residual beats.
